dsp_decimator: RTL
==================

DSP_DECIMATOR -- requirements
Module: dsp_decimator

Interface
REQ-001 The block SHALL take parameter N, default 7, as the MSB index of input and output samples (data width N+1).
REQ-002 The block SHALL take parameter LOG2_D, default 2, as log2 of decimation factor D (default D=4).
REQ-003 The block SHALL take parameter LOG2_DEPTH, default 2, as log2 of output FIFO depth (default 4 entries).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  x carries a new filter output sample this cycle.
REQ-007 x  input  N+1  unsigned sample from the upstream DSP filter output.
REQ-008 out_valid  output  1  y holds a valid decimated sample.
REQ-009 out_ready  input  1  consumer accepts y this cycle.
REQ-010 y  output  N+1  decimated (block-averaged) sample, FIFO head.
REQ-011 fill  output  LOG2_DEPTH+1  number of FIFO entries occupied.
REQ-012 overflow  output  1  sticky flag: at least one result was dropped.

Function
REQ-013 Accumulator SHALL be N+1+LOG2_D bits wide, unsigned; it SHALL never wrap.
REQ-014 Phase counter cnt (0..D-1) SHALL advance only on cycles with in_valid=1; cycles with in_valid=0 SHALL leave acc and cnt unchanged.
REQ-015 On in_valid=1 with cnt<D-1: acc <= acc + x, cnt <= cnt+1.
REQ-016 On in_valid=1 with cnt=D-1: result = (acc + x) >> LOG2_D (truncation, no rounding), acc <= 0, cnt <= 0, push request issued the same edge.
REQ-017 FIFO SHALL be first-word-fall-through: y and out_valid reflect the head entry; out_valid = (fill != 0).
REQ-018 Latency: result from the D-th sample accepted at edge k SHALL appear on y with out_valid=1 after edge k if the FIFO was empty (one cycle).
REQ-019 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-020 Push while fill<DEPTH SHALL store the result at the tail; order SHALL be strictly FIFO.
REQ-021 Push while fill=DEPTH and no pop same edge SHALL drop the new result, leave contents unchanged, set overflow=1.
REQ-022 Push and pop on the same edge with fill=DEPTH SHALL both succeed; fill stays DEPTH; overflow unchanged.
REQ-023 Push and pop on the same edge with 0<fill<DEPTH SHALL leave fill unchanged.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH without corrupting data.
REQ-025 overflow SHALL be cleared only by rst.
REQ-026 y SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-027 rst=1 at a rising edge SHALL set acc=0, cnt=0, fill=0, out_valid=0, overflow=0, y=0, pointers=0, regardless of other inputs that edge.
REQ-028 Reset mid-block SHALL discard the partial accumulation; the next in_valid sample starts a new block at cnt=0.
REQ-029 A push or pop coinciding with rst SHALL be ignored.

Verification
REQ-030 Defaults, out_ready=1, x=10,20,30,40 on consecutive in_valid cycles -> y=25, out_valid=1 the cycle after 40, out_valid=0 next cycle.
REQ-031 x=1,1,1,2 with in_valid gaps between samples -> sum 5, y=1 (truncation); no output before the 4th valid sample.
REQ-032 x=255 x4 -> y=255, overflow=0 (accumulator width sufficient).
REQ-033 out_ready=0, 20 valid samples forming blocks averaging 1,2,3,4,5 -> fill=4, overflow=1, then out_ready=1 drains y=1,2,3,4 in order, fill returns to 0, overflow stays 1.
REQ-034 fill=4, out_ready=1 on the edge a new result (6) is pushed -> head popped, 6 accepted at tail, fill=4, overflow unchanged.
REQ-035 Two samples 100,100, then rst for one cycle, then x=8 x4 -> y=8, fill=1, overflow=0.

Source files
------------

// File: rtl/dsp_decimator.sv
// Block-averaging decimator: sums D unsigned samples, emits the truncated mean
// into a small first-word-fall-through FIFO with a sticky overflow flag.
module dsp_decimator #(
  parameter int unsigned N          = 7,
  parameter int unsigned LOG2_D     = 2,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N:0]          x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N:0]          y,
  output logic [LOG2_DEPTH:0] fill,
  output logic                overflow
);
  localparam int unsigned AccW  = N + 1 + LOG2_D;
  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam logic [LOG2_D-1:0]   CntMax  = '1;
  localparam logic [LOG2_DEPTH:0] FillMax = {1'b1, {LOG2_DEPTH{1'b0}}};

  logic [AccW-1:0]       acc_q, acc_d, sum;
  logic [LOG2_D-1:0]     cnt_q, cnt_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  logic                  overflow_q;
  logic [N:0]            mem_q [Depth];
  logic [N:0]            result;
  logic                  push, pop, full, do_push;

  // D samples of N+1 bits fit in N+1+LOG2_D bits, so the sum cannot wrap.
  assign sum     = acc_q + {{LOG2_D{1'b0}}, x};
  assign result  = sum[AccW-1:LOG2_D];
  assign push    = in_valid && (cnt_q == CntMax);
  assign full    = (fill_q == FillMax);
  assign pop     = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || pop);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    fill_d = fill_q;
    if (in_valid) begin
      if (push) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (do_push && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!do_push && pop) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= result;
  end

  assign out_valid = (fill_q != '0);
  // Storage is not reset; gate the head so y reads zero while empty.
  assign y         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fill      = fill_q;
  assign overflow  = overflow_q;

endmodule
